// File: rtl/kyber_pkg.sv
// kyber_pkg: Kyber768 public-key constants and the loader state type.
package kyber_pkg;
    localparam int KYBER_N    = 256;
    localparam int KYBER_K    = 3;
    localparam int KYBER_Q    = 3329;
    localparam int COEFF_W    = 12;
    localparam int RHO_BITS   = 256;
    localparam int NUM_COEFFS = KYBER_N * KYBER_K;
    localparam int PK_BITS    = RHO_BITS + NUM_COEFFS * COEFF_W;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_DONE} ld_state_e;
endpackage

// File: rtl/pk_loader_if.sv
// pk_loader_if: valid/ready word stream carrying the public key into the loader.
interface pk_loader_if #(
    parameter int WORD_W = 64
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, in_valid, input in_ready);
    modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/coeff_range_check.sv
// coeff_range_check: flags whether any of CHK_LANES 12-bit coefficients is >= q.
module coeff_range_check
    import kyber_pkg::*;
#(
    parameter int CHK_LANES = 1
) (
    input  logic [CHK_LANES*COEFF_W-1:0] coeffs,
    output logic                         any_bad
);
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < CHK_LANES; i++)
            any_bad = any_bad | (coeffs[i*COEFF_W +: COEFF_W] >= COEFF_W'(KYBER_Q));
    end
endmodule

// File: rtl/pk_loader.sv
// pk_loader: assembles the Kyber768 public key from a word stream, then
// range-checks every t coefficient before handing the key to decode.
module pk_loader
    import kyber_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int CHK_LANES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    pk_loader_if.slave         in_if,
    output logic [PK_BITS-1:0] pk_out,
    output logic               pk_valid,
    output logic               pk_error,
    output logic               done,
    output logic               busy
);
    localparam int NUM_WORDS  = PK_BITS / WORD_W;
    localparam int NUM_GROUPS = NUM_COEFFS / CHK_LANES;
    localparam int LANE_BITS  = CHK_LANES * COEFF_W;
    localparam int CNT_W      = $clog2(NUM_WORDS > NUM_GROUPS ? NUM_WORDS : NUM_GROUPS);

    if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32 || WORD_W == 64 ||
          WORD_W == 128 || WORD_W == 256))
        $fatal(1, "pk_loader: illegal WORD_W");
    if (!(CHK_LANES == 1 || CHK_LANES == 2 || CHK_LANES == 4 || CHK_LANES == 8 ||
          CHK_LANES == 16))
        $fatal(1, "pk_loader: illegal CHK_LANES");

    ld_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PK_BITS-1:0]   pk_q, pk_d;
    logic                 valid_q, valid_d, err_q, err_d, done_q, done_d;
    logic                 go, hs, last_word, last_group, lane_bad;
    logic [LANE_BITS-1:0] lanes;

    assign go         = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign hs         = in_if.in_valid && state_q == ST_LOAD;
    assign last_word  = cnt_q == CNT_W'(NUM_WORDS - 1);
    assign last_group = cnt_q == CNT_W'(NUM_GROUPS - 1);
    // one counter serves both phases: word index in LOAD, lane group in CHECK
    assign lanes      = pk_q[RHO_BITS + int'(cnt_q) * LANE_BITS +: LANE_BITS];

    coeff_range_check #(.CHK_LANES(CHK_LANES)) u_chk (
        .coeffs  (lanes),
        .any_bad (lane_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pk_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pk_q    <= pk_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = go                                  ? ST_LOAD  :
                  (hs && last_word)                   ? ST_CHECK :
                  (state_q == ST_CHECK && last_group) ? ST_DONE  : state_q;
    end

    always_comb begin
        pk_d = pk_q;
        if (hs) pk_d[int'(cnt_q) * WORD_W +: WORD_W] = in_if.in_data;
        cnt_d   = (go || (hs && last_word) || (state_q == ST_CHECK && last_group)) ? '0 :
                  (hs || state_q == ST_CHECK) ? cnt_q + 1'b1 : cnt_q;
        valid_d = state_d == ST_DONE;
        err_d   = go ? 1'b0 : err_q | (state_q == ST_CHECK && lane_bad);
        done_d  = state_q == ST_CHECK && state_d == ST_DONE;
    end

    always_comb begin
        in_if.in_ready = state_q == ST_LOAD;
        busy           = state_q == ST_LOAD || state_q == ST_CHECK;
        pk_out         = pk_q;
        pk_valid       = valid_q;
        pk_error       = err_q;
        done           = done_q;
    end
endmodule

// File: tb/tb_pk_loader.sv
// tb_pk_loader: directed bench with a transaction-level key model checked every cycle.
module tb_pk_loader;
    import kyber_pkg::*;

    localparam int NW = PK_BITS / 64;

    logic clk = 1'b0, rst_n = 1'b1, start1 = 1'b0, start8 = 1'b0;
    logic [63:0] tb_data = '0;
    logic        tb_valid = 1'b0;
    logic [PK_BITS-1:0] pk1, pk8;
    logic valid1, err1, done1, busy1, valid8, err8, done8, busy8;
    int   errors = 0, checks = 0, ready_cnt = 0;
    bit   cmp_on = 0;

    pk_loader_if #(.WORD_W(64)) if1 ();
    pk_loader_if #(.WORD_W(64)) if8 ();
    assign if1.in_data = tb_data;
    assign if1.in_valid = tb_valid;
    assign if8.in_data = tb_data;
    assign if8.in_valid = tb_valid;

    pk_loader #(.WORD_W(64), .CHK_LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_if(if1.slave),
        .pk_out(pk1), .pk_valid(valid1), .pk_error(err1), .done(done1), .busy(busy1));
    pk_loader #(.WORD_W(64), .CHK_LANES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .in_if(if8.slave),
        .pk_out(pk8), .pk_valid(valid8), .pk_error(err8), .done(done8), .busy(busy8));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_key(input string n, input logic [PK_BITS-1:0] a, input logic [PK_BITS-1:0] e);
        int w;
        checks++;
        if (a !== e) begin
            errors++;
            w = 0;
            while (w < NW - 1 && a[w*64 +: 64] === e[w*64 +: 64]) w++;
            $display("FAIL %s word %0d: got %h want %h at %0t", n, w, a[w*64 +: 64], e[w*64 +: 64], $time);
        end
    endtask

    function automatic bit key_bad(input logic [PK_BITS-1:0] key);
        for (int j = 0; j < NUM_COEFFS; j++)
            if (key[RHO_BITS + 12*j +: 12] >= 12'd3329) return 1'b1;
        return 1'b0;
    endfunction

    // kind: 0 clean, 1 coeff767=3328, 2 coeff0=3329, 3 coeff400=0xFFF, 4 rho all ones
    function automatic logic [PK_BITS-1:0] build_key(input int kind);
        logic [PK_BITS-1:0] key;
        for (int k = 0; k < NW; k++) key[k*64 +: 64] = {32'(k), ~32'(k)};
        for (int j = 0; j < NUM_COEFFS; j++) key[RHO_BITS + 12*j + 8 +: 4] = 4'h0;
        case (kind)
            1: key[RHO_BITS + 12*767 +: 12] = 12'd3328;
            2: key[RHO_BITS +: 12] = 12'd3329;
            3: key[RHO_BITS + 12*400 +: 12] = 12'hFFF;
            4: key[RHO_BITS-1:0] = '1;
            default: ;
        endcase
        return key;
    endfunction

    // reference model for the CHK_LANES=1 instance: key image, phase and check countdown
    logic [PK_BITS-1:0] m_key;
    int m_phase, m_cnt, m_rem;
    bit m_valid, m_err, m_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key <= '0; m_phase <= 0; m_cnt <= 0; m_rem <= 0;
            m_valid <= 0; m_err <= 0; m_done <= 0;
        end else begin
            m_done <= 0;
            case (m_phase)
                0, 3: if (start1) begin
                    m_phase <= 1; m_cnt <= 0; m_valid <= 0; m_err <= 0;
                end
                1: if (tb_valid) begin
                    m_key[m_cnt*64 +: 64] <= tb_data;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == NW - 1) begin m_phase <= 2; m_rem <= NUM_COEFFS; end
                end
                2: begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_phase <= 3; m_done <= 1; m_valid <= 1; m_err <= key_bad(m_key);
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) if (cmp_on) begin
        chk("in_ready", if1.in_ready, m_phase == 1);
        chk("busy", busy1, m_phase == 1 || m_phase == 2);
        chk("done", done1, m_done);
        chk("pk_valid", valid1, m_valid);
        if (m_phase != 2) chk("pk_error", err1, m_err);
        chk_key("pk_out", pk1, m_key);
    end

    always @(negedge clk) if (if1.in_ready) ready_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input bit sel, input logic [PK_BITS-1:0] key, input int gap_pct,
                            input int stop_after, input bit poke);
        int n;
        if (sel) start8 = 1'b1; else start1 = 1'b1;
        step();
        start1 = 1'b0; start8 = 1'b0;
        if (!sel) begin
            chk("start pk_valid", valid1, 1'b0);
            chk("start pk_error", err1, 1'b0);
        end
        for (int k = 0; k < NW && k < stop_after; k++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                tb_valid = 1'b0; tb_data = {$urandom, $urandom};
                step();
            end
            tb_valid = 1'b1;
            tb_data = key[k*64 +: 64];
            if (poke && k == 70) start1 = 1'b1;
            n = 0;
            while (!(sel ? if8.in_ready : if1.in_ready) && n < 50) begin step(); n++; end
            if (n >= 50) chk("ready timeout", 0, 1);
            step();
            start1 = 1'b0;
        end
        tb_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int lat, input bit poke);
        int c = 0;
        while (c < 2000) begin
            tb_valid = 1'b1; tb_data = {$urandom, $urandom};
            if (poke && (c == 100 || c == lat - 1)) start1 = 1'b1;
            step();
            start1 = 1'b0;
            c++;
            if (sel ? done8 : done1) break;
        end
        chk(sel ? "done latency x8" : "done latency", c, lat);
        for (int i = 0; i < 3; i++) begin tb_data = {$urandom, $urandom}; step(); end
        tb_valid = 1'b0;
        chk(sel ? "held pk_valid x8" : "held pk_valid", sel ? valid8 : valid1, 1'b1);
    endtask

    initial begin
        logic [PK_BITS-1:0] clean;
        clean = build_key(0);
        #2 rst_n = 1'b0;
        #1 cmp_on = 1;
        chk("rst pk_out", |pk1, 0);
        chk("rst in_ready", if1.in_ready, 0);
        chk("rst busy", busy1, 0);
        chk("rst pk_valid", valid1, 0);
        chk("rst done", done1, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin tb_valid = 1'b1; tb_data = {$urandom, $urandom}; step(); end
        tb_valid = 1'b0;

        load_key(0, clean, 0, 50, 0);
        chk("mid-load busy", busy1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst pk_out", |pk1, 0);
        chk("midrst in_ready", if1.in_ready, 0);
        chk("midrst busy", busy1, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        step();

        ready_cnt = 0;
        load_key(0, clean, 0, NW, 1);
        chk("in_ready cycles", ready_cnt, 148);
        wait_done(0, 768, 1);
        chk("clean pk_error", err1, 0);
        chk_key("clean pk_out", pk1, clean);
        chk("word0 literal", pk1[63:0], 64'h00000000_FFFFFFFF);
        chk("word1 literal", pk1[127:64], 64'h00000001_FFFFFFFE);

        load_key(0, build_key(2), 0, NW, 0);
        wait_done(0, 768, 0);
        chk("coeff0=3329 err", err1, 1);
        load_key(0, build_key(3), 0, NW, 0);
        wait_done(0, 768, 0);
        chk("coeff400=fff err", err1, 1);
        load_key(0, build_key(1), 0, NW, 0);
        wait_done(0, 768, 0);
        chk("coeff767=3328 err", err1, 0);
        load_key(0, build_key(4), 0, NW, 0);
        wait_done(0, 768, 0);
        chk("rho ones err", err1, 0);

        load_key(0, clean, 30, NW, 0);
        wait_done(0, 768, 0);
        chk_key("gapped pk_out", pk1, clean);

        load_key(1, clean, 0, NW, 0);
        wait_done(1, 96, 0);
        chk_key("x8 pk_out", pk8, clean);
        chk("x8 pk_error", err8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pk_loader.md
Name: pk_loader

Overview:
- Upstream of the public-key decode stage in encapsulation.
- Accepts the 1184-byte Kyber768 public key as a valid/ready word stream and assembles it into a 9472-bit register in decode layout: rho in bits [255:0], t polynomials in bits [9471:256].
- Then runs the modulus check, one pass over all 768 12-bit t coefficients, flagging any coefficient >= 3329.
- Presents the held key with pk_valid/pk_error to the decode stage.

Parameters:
- WORD_W, 64, input word width; must divide 9472 (legal: 8, 16, 32, 64, 128, 256).
- CHK_LANES, 1, coefficients checked per cycle in CHECK; must divide 768 (1, 2, 4, 8, 16).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new load; sampled only in IDLE or DONE.
- in_data  input  WORD_W  key word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- pk_out  output  9472  assembled public key, registered.
- pk_valid  output  1  level; pk_out complete and checked.
- pk_error  output  1  level, valid with pk_valid; at least one t coefficient >= 3329.
- done  output  1  one-cycle pulse on entry to DONE.
- busy  output  1  high in LOAD and CHECK.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, pk_out 0, and in_ready, pk_valid, pk_error, done, busy all 0.
- States: IDLE, LOAD, CHECK, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> CHECK on the handshake of word NUM_WORDS-1, where NUM_WORDS = 9472/WORD_W.
  - CHECK -> DONE after the last lane group.
  - DONE -> LOAD on start.
- in_ready = 1 exactly when state is LOAD; combinational from state only, never from in_valid.
- Handshake is in_valid & in_ready at a rising edge. Word k (0-based arrival order) is written to pk_out[k*WORD_W +: WORD_W]. With WORD_W=64, words 0..3 are rho.
- in_valid outside LOAD: ignored, no data consumed.
- Data held while in_valid=0 in LOAD: counter and pk_out are unchanged; no timeout.
- Entering LOAD from IDLE or DONE:
  - word counter := 0, pk_valid := 0, pk_error := 0.
  - pk_out is not cleared; it is overwritten word by word.
- CHECK:
  - Coefficient j (0..767) is pk_out[256 + 12*j +: 12].
  - Each cycle, lanes j = c*CHK_LANES .. c*CHK_LANES+CHK_LANES-1 are compared unsigned against 3329.
  - An error flag is ORed in; it is sticky until the next start.
  - c counts 0 .. 768/CHK_LANES-1.
- CHECK duration is exactly 768/CHK_LANES cycles. With last-word handshake at edge E, the state is DONE, pk_valid=1 and done=1 after edge E + 768/CHK_LANES.
  - Defaults: 148 handshake cycles + 768 check cycles.
- DONE:
  - pk_valid held at 1, pk_error stable, pk_out stable.
  - done high only on the first DONE cycle.
- start during LOAD or CHECK: ignored, operation continues.
- start in the same cycle as entry to DONE: not acted on; it is sampled only once the state is DONE.
- rst_n asserted mid-LOAD or mid-CHECK: immediate return to reset values; the partial key is discarded.
- rho bits are never range-checked. Coefficient value 3328 is legal; 3329 and 4095 are errors.
- Parameter legality enforced at elaboration; an illegal value is a fatal error.

Decomposition:
- Shared package kyber_pkg:
  - KYBER_Q = 3329, PK_BITS = 9472, NUM_COEFFS = 768, COEFF_W = 12.
  - State enum typedef for the loader FSM.
  - Reuse KYBER_N, KYBER_K, KYBER_R_WIDTH from params.vh.
- Sub-module coeff_range_check:
  - Combinational, CHK_LANES x 12-bit inputs, single OR-reduced output flag "any >= KYBER_Q".
  - Reused later by other decode paths.

Test Plan:
- Reset mid-stream: assert rst_n=0 after 50 words -> all outputs 0 immediately, state IDLE; a subsequent start plus 148 words loads cleanly.
- Clean key, WORD_W=64, in_valid always 1:
  - Stream words word_k = {k, ~k} with coefficient upper nibbles masked so all coefficients are < 3329.
  - Expect in_ready high for exactly 148 cycles, pk_valid=1, pk_error=0.
  - Expect done pulse 768 cycles after the last handshake, and pk_out[64k +: 64] == word_k.
- Boundary coefficients:
  - Coefficient 767 = 3328 -> pk_error=0.
  - Rerun with coefficient 0 = 3329 -> pk_error=1.
  - Rerun with coefficient 400 = 0xFFF -> pk_error=1.
  - rho = all ones -> pk_error=0.
- Backpressure and noise:
  - Random in_valid gaps in LOAD -> pk_out identical to the gap-free run.
  - in_valid=1 with junk data in IDLE, CHECK and DONE -> no pk_out change.
  - start pulsed during LOAD and CHECK -> ignored.
- Reload from DONE: error key loaded (pk_error=1), then start -> pk_valid and pk_error drop the next cycle; a clean key then ends with pk_error=0.
- CHK_LANES=8 instance: same clean key -> done exactly 96 cycles after the last handshake.
